ic74x259: RTL and testbench

Cycle-based FPGA emulation of the 74x259 8-bit addressable latch, the 1-to-8 write-side counterpart of the 8-to-1 data selector. It takes a 3-bit address, a data bit and the active-low enable and clear pins, and updates one of eight stored output bits per clock. Pins from the emulated TTL board are sampled on the system clock, with optional synchronizers and a settle filter. Pin numbering follows the TI SN74LS259 datasheet.

---
 rtl/ic74x259.sv | 161 ++++++++++++++++
 tb/tb_ic74x259.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ic74x259.sv
// ic74x259 -- cycle-based emulation of the 74x259 8-bit addressable latch.
//
// Board pins are sampled on clk. An optional 2-flop synchronizer
// (IC74X259_SYNC_EN) and an optional settle filter (SETTLE_CYCLES) sit
// between the pins and the mode decode. Q0..Q7 come straight from flops.
//
// Parameters:
//   SETTLE_CYCLES  consecutive unchanged samples needed before a commit
//                  (0 = commit every cycle), legal range 0..15
// Macro:
//   IC74X259_SYNC_EN  when defined, every input pin passes through a 2-flop
//                     synchronizer (adds 2 cycles of latency)
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   port1..port3    S0..S2 address (port3 = MSB)
//   port13          D, data
//   port14          /G, enable, active-low
//   port15          /CLR, clear, active-low
//   port4..port7    Q0..Q3
//   port9..port12   Q4..Q7
module ic74x259 #(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic port1,
  input  logic port2,
  input  logic port3,
  output logic port4,
  output logic port5,
  output logic port6,
  output logic port7,
  output logic port9,
  output logic port10,
  output logic port11,
  output logic port12,
  input  logic port13,
  input  logic port14,
  input  logic port15
);

  // Sample layout: {addr[2:0], D, /G, /CLR}. The reset value decodes as
  // memory mode so leaving reset can never write anything.
  localparam logic [5:0] IDLE_SAMPLE = 6'b000_0_1_1;
  localparam logic [3:0] SETTLE      = 4'(SETTLE_CYCLES);

  logic [5:0] pins;
  logic [5:0] s;

  assign pins = {port3, port2, port1, port13, port14, port15};

`ifdef IC74X259_SYNC_EN
  logic [5:0] sync1_reg;
  logic [5:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= IDLE_SAMPLE;
      sync2_reg <= IDLE_SAMPLE;
    end else begin
      sync1_reg <= pins;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = sync2_reg;
`else
  assign s = pins;
`endif

  // Settle filter. cnt_next is the count including the current sample, so
  // a commit happens on the very edge the count reaches SETTLE; with
  // SETTLE = 0 the count is pinned at 0 and every cycle commits.
  logic [5:0] prev_reg;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic       commit;

  always_comb begin
    cnt_next = cnt_reg;
    if (s != prev_reg) begin
      cnt_next = 4'd0;
    end else if (cnt_reg != SETTLE) begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  assign commit = (cnt_next == SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= IDLE_SAMPLE;
      cnt_reg  <= 4'd0;
    end else begin
      prev_reg <= s;
      cnt_reg  <= cnt_next;
    end
  end

  // Mode decode
  logic [2:0] addr;
  logic       d;
  logic       g_n;
  logic       clr_n;

  assign addr  = s[5:3];
  assign d     = s[2];
  assign g_n   = s[1];
  assign clr_n = s[0];

  logic [7:0] q_reg;
  logic [7:0] q_next;

  // Per-bit next state:
  //   /CLR=0,/G=1  clear          -> 0
  //   /G=0         selected bit   -> D
  //   /CLR=0,/G=0  other bits     -> 0 (demux)
  //   otherwise                   -> hold
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      logic sel;
      logic bit_val;

      assign sel = (addr == 3'(gi));

      always_comb begin
        bit_val = q_reg[gi];
        if (!clr_n && g_n) begin
          bit_val = 1'b0;
        end else if (!g_n) begin
          if (sel) begin
            bit_val = d;
          end else if (!clr_n) begin
            bit_val = 1'b0;
          end
        end
      end

      assign q_next[gi] = commit ? bit_val : q_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 8'h00;
    end else begin
      q_reg <= q_next;
    end
  end

  assign port4  = q_reg[0];
  assign port5  = q_reg[1];
  assign port6  = q_reg[2];
  assign port7  = q_reg[3];
  assign port9  = q_reg[4];
  assign port10 = q_reg[5];
  assign port11 = q_reg[6];
  assign port12 = q_reg[7];

endmodule

// File: tb/tb_ic74x259.sv
// Directed testbench for ic74x259. Two instances share the pins: dut0 with
// SETTLE_CYCLES = 0 and dut3 with SETTLE_CYCLES = 3. Inputs are driven 1 ns
// after a rising edge, outputs are checked 1 ns after a rising edge.
module tb_ic74x259;

`ifdef IC74X259_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int L0 = 1 + SYNC;      // latency for SETTLE_CYCLES = 0
  localparam int L3 = 1 + SYNC + 3;  // latency for SETTLE_CYCLES = 3

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] a = 3'd0;
  logic       d = 1'b0;
  logic       g_n = 1'b1;
  logic       clr_n = 1'b1;
  wire  [7:0] q0;
  wire  [7:0] q3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic74x259 #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .port1(a[0]), .port2(a[1]), .port3(a[2]),
    .port4(q0[0]), .port5(q0[1]), .port6(q0[2]), .port7(q0[3]),
    .port9(q0[4]), .port10(q0[5]), .port11(q0[6]), .port12(q0[7]),
    .port13(d), .port14(g_n), .port15(clr_n)
  );

  ic74x259 #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .port1(a[0]), .port2(a[1]), .port3(a[2]),
    .port4(q3[0]), .port5(q3[1]), .port6(q3[2]), .port7(q3[3]),
    .port9(q3[4]), .port10(q3[5]), .port11(q3[6]), .port12(q3[7]),
    .port13(d), .port14(g_n), .port15(clr_n)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latch a full byte into dut0 one address per cycle, then go to memory
  // mode and let the pipeline drain.
  task automatic write_byte(input logic [7:0] v);
    clr_n = 1'b1;
    g_n   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      d = v[i];
      tick(1);
    end
    g_n = 1'b1;
    tick(L0);
  endtask

  task automatic set_idle();
    a = 3'd0; d = 1'b0; g_n = 1'b1; clr_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (q0 !== 8'h00) begin
      errors++; $display("FAIL reset_hold: q=%02h expected 00", q0);
    end
    tick(2);
    clr_n = 1'b1; g_n = 1'b0; a = 3'd5; d = 1'b1;
    rst_n = 1'b1;
    checks++;
    if (q0 !== 8'h00) begin
      errors++; $display("FAIL reset_release: q=%02h expected 00", q0);
    end
    if (L0 > 1) tick(L0 - 1);
    checks++;
    if (q0 !== 8'h00) begin
      errors++; $display("FAIL reset_prelatch: q=%02h expected 00", q0);
    end
    tick(1);
    checks++;
    if (q0 !== 8'h20) begin
      errors++; $display("FAIL reset_latch: q=%02h expected 20", q0);
    end
    $display("test_reset: q=%02h", q0);
  endtask

  task automatic test_memory();
    int bad = 0;
    write_byte(8'hA5);
    checks++;
    if (q0 !== 8'hA5) begin
      errors++; $display("FAIL mem_load: q=%02h expected a5", q0);
    end
    for (int i = 0; i < 20; i++) begin
      a = 3'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 1));
      tick(1);
      if (q0 !== 8'hA5) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mem_hold: %0d cycles differed, q=%02h expected a5", bad, q0);
    end
    $display("test_memory: q=%02h", q0);
  endtask

  task automatic test_demux();
    write_byte(8'hFF);
    clr_n = 1'b0; g_n = 1'b0; a = 3'd3; d = 1'b1;
    tick(L0);
    checks++;
    if (q0 !== 8'h08) begin
      errors++; $display("FAIL demux_d1: q=%02h expected 08", q0);
    end
    d = 1'b0;
    tick(L0);
    checks++;
    if (q0 !== 8'h00) begin
      errors++; $display("FAIL demux_d0: q=%02h expected 00", q0);
    end
    $display("test_demux: q=%02h", q0);
  endtask

  task automatic test_clear();
    write_byte(8'h5A);
    clr_n = 1'b0; g_n = 1'b1;
    if (L0 > 1) tick(L0 - 1);
    checks++;
    if (q0 !== 8'h5A) begin
      errors++; $display("FAIL clear_early: q=%02h expected 5a", q0);
    end
    tick(1);
    checks++;
    if (q0 !== 8'h00) begin
      errors++; $display("FAIL clear: q=%02h expected 00", q0);
    end
    // asynchronous reset in the middle of a cycle
    write_byte(8'h5A);
    clr_n = 1'b1; g_n = 1'b0; a = 3'd1; d = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q0 !== 8'h00 || q3 !== 8'h00) begin
      errors++; $display("FAIL async_reset: q0=%02h q3=%02h expected 00", q0, q3);
    end
    set_idle();
    tick(1);
    rst_n = 1'b1;
    $display("test_clear: q=%02h", q0);
  endtask

  task automatic test_addr_walk();
    clr_n = 1'b1; g_n = 1'b0; d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 3'(i);
      tick(1);
    end
    g_n = 1'b1;
    tick(L0);
    checks++;
    if (q0 !== 8'h07) begin
      errors++; $display("FAIL addr_walk: q=%02h expected 07", q0);
    end
    $display("test_addr_walk: q=%02h", q0);
  endtask

  task automatic test_settle();
    set_idle();
    rst_n = 1'b0; #1 rst_n = 1'b1;
    tick(4);
    // glitches of 2 and 3 cycles never reach a full settle window
    for (int w = 2; w <= 3; w++) begin
      g_n = 1'b0; a = 3'd6; d = 1'b1;
      tick(w + SYNC);
      g_n = 1'b1;
      tick(8);
      checks++;
      if (q3 !== 8'h00) begin
        errors++; $display("FAIL settle_glitch%0d: q=%02h expected 00", w, q3);
      end
    end
    g_n = 1'b0; a = 3'd6; d = 1'b1;
    tick(L3 - 1);
    checks++;
    if (q3 !== 8'h00) begin
      errors++; $display("FAIL settle_early: q=%02h expected 00", q3);
    end
    tick(1);
    checks++;
    if (q3 !== 8'h40) begin
      errors++; $display("FAIL settle_commit: q=%02h expected 40", q3);
    end
    $display("test_settle: q=%02h", q3);
  endtask

  task automatic test_reset_mid_filter();
    set_idle();
    tick(2);
    g_n = 1'b0; a = 3'd1; d = 1'b1;
    tick(2);
    rst_n = 1'b0; #1 rst_n = 1'b1;
    tick(L3 - 1);
    checks++;
    if (q3 !== 8'h00) begin
      errors++; $display("FAIL rst_mid_early: q=%02h expected 00", q3);
    end
    tick(1);
    checks++;
    if (q3 !== 8'h02) begin
      errors++; $display("FAIL rst_mid_commit: q=%02h expected 02", q3);
    end
    set_idle();
    $display("test_reset_mid_filter: q=%02h", q3);
  endtask

  initial begin
    test_reset();
    test_memory();
    test_demux();
    test_clear();
    test_addr_walk();
    test_settle();
    test_reset_mid_filter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
